// File: rtl/axi4_lite_wr_sequencer_pkg.sv
// Purpose: shared state encoding and response codes for the AXI4-Lite write sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   state_t        - sequencer FSM states (IDLE, REQ, RESP)
//   RESP_*         - AXI write response codes pushed into the B FIFO
//   ERR_COUNT_MAX  - saturation value of the error counter
package axi4_wr_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [15:0] ERR_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/axi4_lite_wr_sequencer_if.sv
// Purpose: bundle of FIFO-side, backend-side and status signals of the write sequencer.
// Latency: n/a (wiring only).
// Backpressure: B push waits on b_wr_full; backend write waits on wr_ack.
//
// Signal groups:
//   AW FIFO read side : aw_rd_empty, aw_rd_en, aw_addr
//   W  FIFO read side : w_rd_empty, w_rd_en, w_data, w_strb
//   B  FIFO write side: b_wr_full, b_wr_en, b_resp
//   backend port      : wr_req, wr_addr, wr_data, wr_strb, wr_ack, wr_err
//   status            : busy, err_count
// Modports: master = the sequencer, slave = FIFO bank plus backend.
interface axi4_lite_wr_sequencer_if #(
  parameter int A_W = 32,
  parameter int D_W = 32
);

  logic               aw_rd_empty;
  logic               aw_rd_en;
  logic [A_W-1:0]     aw_addr;

  logic               w_rd_empty;
  logic               w_rd_en;
  logic [D_W-1:0]     w_data;
  logic [D_W/8-1:0]   w_strb;

  logic               b_wr_full;
  logic               b_wr_en;
  logic [1:0]         b_resp;

  logic               wr_req;
  logic [A_W-1:0]     wr_addr;
  logic [D_W-1:0]     wr_data;
  logic [D_W/8-1:0]   wr_strb;
  logic               wr_ack;
  logic               wr_err;

  logic               busy;
  logic [15:0]        err_count;

  modport master (
    input  aw_rd_empty, aw_addr,
    input  w_rd_empty, w_data, w_strb,
    input  b_wr_full,
    input  wr_ack, wr_err,
    output aw_rd_en, w_rd_en,
    output b_wr_en, b_resp,
    output wr_req, wr_addr, wr_data, wr_strb,
    output busy, err_count
  );

  modport slave (
    output aw_rd_empty, aw_addr,
    output w_rd_empty, w_data, w_strb,
    output b_wr_full,
    output wr_ack, wr_err,
    input  aw_rd_en, w_rd_en,
    input  b_wr_en, b_resp,
    input  wr_req, wr_addr, wr_data, wr_strb,
    input  busy, err_count
  );

endinterface

// File: rtl/axi4_lite_wr_sequencer.sv
// Purpose: pop AW+W as a pair, decode, do one backend write, push the B response.
// Latency: pop in cycle 0, wr_req from cycle 1, B push earliest the cycle after wr_ack.
// Backpressure: pops only when both AW and W are non-empty; holds in RESP while B is full.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high
//   bus    - master modport: FIFO read/write strobes, backend port, busy, err_count
// Parameters: A_W/D_W bus widths, BASE/SIZE decode window, TIMEOUT ack wait limit.
module axi4_lite_wr_sequencer
  import axi4_wr_seq_pkg::*;
#(
  parameter int              A_W     = 32,
  parameter int              D_W     = 32,
  parameter logic [A_W-1:0]  BASE    = '0,
  parameter int unsigned     SIZE    = 4096,
  parameter int unsigned     TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  axi4_lite_wr_sequencer_if.master    bus
);

  localparam int STRB_W = D_W / 8;

  // Window size widened by one bit so BASE+SIZE never wraps in the compare.
  localparam logic [A_W:0]  SIZE_W   = (A_W+1)'(SIZE);
  // Counter value seen in the last permitted wr_req cycle.
  localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT - 1);

  state_t              state_q,   state_d;
  logic [1:0]          resp_q,    resp_d;
  logic                wr_req_q,  wr_req_d;
  logic [A_W-1:0]      wr_addr_q, wr_addr_d;
  logic [D_W-1:0]      wr_data_q, wr_data_d;
  logic [STRB_W-1:0]   wr_strb_q, wr_strb_d;
  logic [15:0]         tmo_cnt_q, tmo_cnt_d;
  logic [15:0]         err_cnt_q, err_cnt_d;

  logic                pop;
  logic                push;
  logic [A_W-1:0]      offset;
  logic                in_window;

  // FIFO strobes are combinational so a pop/push costs no extra cycle.
  assign pop  = (state_q == IDLE) && !bus.aw_rd_empty && !bus.w_rd_empty;
  assign push = (state_q == RESP) && !bus.b_wr_full;

  // offset < SIZE alone would accept addresses below BASE via wrap-around.
  assign offset    = bus.aw_addr - BASE;
  assign in_window = (bus.aw_addr >= BASE) && ({1'b0, offset} < SIZE_W);

  always_comb begin
    state_d   = state_q;
    resp_d    = resp_q;
    wr_req_d  = wr_req_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_strb_d = wr_strb_q;
    tmo_cnt_d = tmo_cnt_q;
    err_cnt_d = err_cnt_q;

    case (state_q)
      IDLE: begin
        if (pop) begin
          wr_addr_d = offset;
          wr_data_d = bus.w_data;
          wr_strb_d = bus.w_strb;
          tmo_cnt_d = '0;
          if (!in_window) begin
            resp_d  = RESP_DECERR;
            state_d = RESP;
          end else if (bus.w_strb == '0) begin
            // Nothing to write: complete without touching the backend.
            resp_d  = RESP_OKAY;
            state_d = RESP;
          end else begin
            wr_req_d = 1'b1;
            state_d  = REQ;
          end
        end
      end

      REQ: begin
        // An ack in the final timeout cycle still completes normally.
        if (bus.wr_ack) begin
          resp_d   = bus.wr_err ? RESP_SLVERR : RESP_OKAY;
          wr_req_d = 1'b0;
          state_d  = RESP;
        end else if (tmo_cnt_q == TMO_LAST) begin
          resp_d   = RESP_SLVERR;
          wr_req_d = 1'b0;
          state_d  = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end

      RESP: begin
        if (push) begin
          state_d = IDLE;
          if ((resp_q != RESP_OKAY) && (err_cnt_q != ERR_COUNT_MAX)) begin
            err_cnt_d = err_cnt_q + 16'd1;
          end
        end
      end

      default: begin
        state_d  = IDLE;
        wr_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      resp_q    <= RESP_OKAY;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
      tmo_cnt_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      resp_q    <= resp_d;
      wr_req_q  <= wr_req_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_strb_q <= wr_strb_d;
      tmo_cnt_q <= tmo_cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.aw_rd_en  = pop;
  assign bus.w_rd_en   = pop;
  assign bus.b_wr_en   = push;
  assign bus.b_resp    = resp_q;
  assign bus.wr_req    = wr_req_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_strb   = wr_strb_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.err_count = err_cnt_q;

endmodule
